// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing a single-ported 1024x16 memory between the fetch (IF)
// and data (DM) requesters. Optional feature macro: ADDR_RANGE_CHECK_EN (reject ADDR[15:10] != 0).
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic [15:0] dm_addr_i,
  input  logic        dm_we_i,
  input  logic [15:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [15:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [9:0]  mem_addr_o,
  output logic [15:0] mem_din_o,
  input  logic [15:0] mem_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  localparam logic [2:0] LatM1 = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q,  last_d;
  logic [9:0]  addr_q,  addr_d;
  logic        we_q,    we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rej_q;
  logic        grant_dm;
  logic [15:0] sel_addr;

`ifdef ADDR_RANGE_CHECK_EN
  logic rej_d;
`else
  logic addr_hi_unused;
  assign rej_q          = 1'b0;
  assign addr_hi_unused = ^sel_addr[15:10];
`endif

  // On a tie the requester that did not win last time is served.
  assign grant_dm = dm_req_i && (!if_req_i || (last_q == OWN_IF));
  assign sel_addr = grant_dm ? dm_addr_i : if_addr_i;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef ADDR_RANGE_CHECK_EN
    rej_d   = rej_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req_i || dm_req_i) begin
          owner_d = grant_dm ? OWN_DM : OWN_IF;
          addr_d  = sel_addr[9:0];
          we_d    = grant_dm && dm_we_i;
          wdata_d = grant_dm ? dm_wdata_i : wdata_q;
`ifdef ADDR_RANGE_CHECK_EN
          rej_d   = |sel_addr[15:10];
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rej_q || we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = LatM1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_dout_i;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        if (rej_q) rdata_d = 16'h0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_DM;
      addr_q  <= 10'h000;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      cnt_q   <= 3'd0;
      // NOTE: rdata is a visible output with a defined reset value, so unlike a storage array it is reset.
      rdata_q <= 16'h0000;
`ifdef ADDR_RANGE_CHECK_EN
      rej_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef ADDR_RANGE_CHECK_EN
      rej_q   <= rej_d;
`endif
    end
  end

  // Strobes decode straight from state/owner flops; the async reset clears them immediately.
  assign busy_o     = (state_q != S_IDLE);
  assign mem_en_o   = (state_q == S_ISSUE) && !rej_q;
  assign mem_we_o   = mem_en_o && we_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o  = wdata_q;
  assign if_ack_o   = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign dm_ack_o   = (state_q == S_RESP) && (owner_q == OWN_DM);
  assign err_o      = (state_q == S_RESP) && rej_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, each with a memory model.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack1, dm_ack1, err1, busy1, mem_en1, mem_we1;
  logic [15:0] rdata1, mem_din1, mem_dout1;
  logic [9:0]  mem_addr1;

  logic        if_req3;
  logic [15:0] if_addr3;
  logic        dm_req3, dm_we3;
  logic [15:0] dm_addr3, dm_wdata3;
  logic        if_ack3, dm_ack3, err3, busy3, mem_en3, mem_we3;
  logic [15:0] rdata3, mem_din3, mem_dout3;
  logic [9:0]  mem_addr3;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];
  logic [15:0] p0, p1, p2;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack1),
    .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_we_i(dm_we), .dm_wdata_i(dm_wdata), .dm_ack_o(dm_ack1),
    .rdata_o(rdata1), .err_o(err1), .busy_o(busy1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_din_o(mem_din1),
    .mem_dout_i(mem_dout1)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_ack_o(if_ack3),
    .dm_req_i(dm_req3), .dm_addr_i(dm_addr3), .dm_we_i(dm_we3), .dm_wdata_i(dm_wdata3), .dm_ack_o(dm_ack3),
    .rdata_o(rdata3), .err_o(err3), .busy_o(busy3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3), .mem_din_o(mem_din3),
    .mem_dout_i(mem_dout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: latency-1 registered read, and a three-stage read pipeline.
  always @(posedge clk) begin
    if (ld_en) begin
      mem1[ld_addr] <= ld_data;
      mem3[ld_addr] <= ld_data;
    end else begin
      if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_din1;
      if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_din3;
    end
    if (mem_en1 && !mem_we1) mem_dout1 <= mem1[mem_addr1];
    p0 <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : p0;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_dout3 = p2;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_en;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    int  en_extra;
    bit  got;
    check($sformatf("v%0d_idle", idx), busy1, 1'b0);
    if_req = !v.is_dm; dm_req = v.is_dm;
    if_addr = v.addr;  dm_addr = v.addr; dm_we = v.we; dm_wdata = v.wdata;
    step();
    if_addr = 16'hFFFF; dm_addr = 16'hFFFF; dm_wdata = 16'hDEAD; dm_we = !v.we;
    check($sformatf("v%0d_en", idx), mem_en1, v.exp_en);
    check($sformatf("v%0d_we", idx), mem_we1, v.exp_en && v.we);
    if (v.exp_en) check($sformatf("v%0d_maddr", idx), mem_addr1, v.addr[9:0]);
    if (v.exp_en && v.we) check($sformatf("v%0d_mdin", idx), mem_din1, v.wdata);
    lat = 1; en_extra = 0; got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (mem_en1) en_extra++;
      if (if_ack1 || dm_ack1) got = 1'b1;
    end
    check($sformatf("v%0d_ack_seen", idx), got, 1'b1);
    check($sformatf("v%0d_lat", idx), lat, v.exp_lat);
    check($sformatf("v%0d_owner", idx), {if_ack1, dm_ack1}, {!v.is_dm, v.is_dm});
    check($sformatf("v%0d_rdata", idx), rdata1, v.exp_rdata);
    check($sformatf("v%0d_err", idx), err1, v.exp_err);
    check($sformatf("v%0d_en_once", idx), en_extra, 0);
    if_req = 1'b0; dm_req = 1'b0;
    step();
  endtask

  initial begin
    int          n_acks;
    int          overlap;
    int          lat;
    int          en_cnt;
    bit          got;
    logic        exp_owner [4];
    logic [15:0] exp_tie_rd [4];

    vecs[0] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 16'h03FF, 16'h1234, 1'b1, 16'hBEEF, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b1, 16'h1234, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'h5555, 1'b1, 16'hA5A5, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h5555, 1'b0, 3};
`ifdef ADDR_RANGE_CHECK_EN
    vecs[6] = '{1'b1, 1'b0, 16'h0401, 16'h0000, 1'b0, 16'h0000, 1'b1, 2};
    vecs[7] = '{1'b0, 1'b0, 16'h8402, 16'h0000, 1'b0, 16'h0000, 1'b1, 2};
    vecs[8] = '{1'b1, 1'b1, 16'h0401, 16'h9999, 1'b0, 16'h0000, 1'b1, 2};
    vecs[9] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h1111, 1'b0, 3};
`else
    vecs[6] = '{1'b1, 1'b0, 16'h0401, 16'h0000, 1'b1, 16'h1111, 1'b0, 3};
    vecs[7] = '{1'b0, 1'b0, 16'h8402, 16'h0000, 1'b1, 16'h2222, 1'b0, 3};
    vecs[8] = '{1'b1, 1'b1, 16'h0401, 16'h9999, 1'b1, 16'h2222, 1'b0, 2};
    vecs[9] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h9999, 1'b0, 3};
`endif
    exp_owner  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_tie_rd = '{16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F};

    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0; dm_req3 = 1'b0; dm_addr3 = '0; dm_we3 = 1'b0; dm_wdata3 = '0;

    load(10'h000, 16'hA5A5);
    load(10'h001, 16'h1111);
    load(10'h002, 16'h2222);
    load(10'h005, 16'hBEEF);
    load(10'h3FF, 16'h0F0F);

    check("rst_busy",  busy1, 1'b0);
    check("rst_acks",  {if_ack1, dm_ack1}, 2'b00);
    check("rst_err",   err1, 1'b0);
    check("rst_en_we", {mem_en1, mem_we1}, 2'b00);
    check("rst_maddr", mem_addr1, 10'h000);
    check("rst_mdin",  mem_din1, 16'h0000);
    check("rst_rdata", rdata1, 16'h0000);
    check("rst3_busy_rdata", {busy3, rdata3}, 17'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Both requesters held high: grants must alternate starting with IF.
    if_req = 1'b1; if_addr = 16'h0005;
    dm_req = 1'b1; dm_addr = 16'h03FF; dm_we = 1'b0;
    n_acks = 0; overlap = 0;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      step();
      if (if_ack1 && dm_ack1) overlap++;
      if (if_ack1 || dm_ack1) begin
        check($sformatf("tie%0d_owner", n_acks), dm_ack1, exp_owner[n_acks]);
        check($sformatf("tie%0d_rdata", n_acks), rdata1, exp_tie_rd[n_acks]);
        n_acks++;
        if (n_acks == 4) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
    end
    check("tie_acks", n_acks, 4);
    check("tie_overlap", overlap, 0);
    step();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // MEM_LAT=3 read: ACK five cycles after sampling, one enable cycle.
    if_req3 = 1'b1; if_addr3 = 16'h0005;
    step();
    check("lat3_maddr", mem_addr3, 10'h005);
    en_cnt = mem_en3 ? 1 : 0;
    lat = 1; got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (mem_en3) en_cnt++;
      if (if_ack3) got = 1'b1;
    end
    check("lat3_ack_seen", got, 1'b1);
    check("lat3_lat", lat, 5);
    check("lat3_rdata", rdata3, 16'hBEEF);
    check("lat3_en_cnt", en_cnt, 1);
    if_req3 = 1'b0;
    step();

    // Reset during WAIT abandons the read; held IF request is served first afterwards.
    if_req = 1'b1; if_addr = 16'h0005;
    dm_req = 1'b1; dm_addr = 16'h03FF; dm_we = 1'b0;
    step();
    step();
    check("mid_busy_pre", {busy1, mem_en1}, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", busy1, 1'b0);
    check("mid_en_we", {mem_en1, mem_we1}, 2'b00);
    check("mid_acks", {if_ack1, dm_ack1}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (if_ack1 || dm_ack1) got = 1'b1;
    end
    check("post_rst_ack_seen", got, 1'b1);
    check("post_rst_owner", {if_ack1, dm_ack1}, 2'b10);
    check("post_rst_lat", lat, 3);
    check("post_rst_rdata", rdata1, 16'hBEEF);
    if_req = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (dm_ack1) got = 1'b1;
    end
    check("post_rst_dm_seen", got, 1'b1);
    dm_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and round-robin arbiter for the single-ported 1024×16 main memory. It shares the memory between the instruction-fetch requester (IF) and the data-memory requester (DM). For the winning requester it truncates the 16-bit address to the 10-bit memory address, drives the memory strobes, waits the memory's read latency, and returns data with a one-cycle acknowledge. It sits between the processor control/datapath and the memory block, replacing the bare 2:1 address select with a handshaked, fair access path.

## Interface
- MEM_LAT, 1, memory read latency in cycles; legal range 1..7.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch request; level, held until IF_ACK.
- IF_ADDR  in  16  fetch address.
- IF_ACK  out  1  one-cycle pulse; RDATA is valid in the same cycle.
- DM_REQ  in  1  data request; level, held until DM_ACK.
- DM_ADDR  in  16  data address.
- DM_WE  in  1  1 = write, 0 = read.
- DM_WDATA  in  16  write data.
- DM_ACK  out  1  one-cycle pulse; RDATA is valid for reads.
- RDATA  out  16  registered read data, shared by both requesters.
- ERR  out  1  pulses with ACK when the access was rejected (see Configuration).
- BUSY  out  1  high in every state except IDLE.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  10  memory address, equal to the granted ADDR[9:0].
- MEM_DIN  out  16  memory write data.
- MEM_DOUT  in  16  memory read data; valid MEM_LAT cycles after the enabled edge.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - No REQ: stay in IDLE.
  - Any REQ: arbitrate, then register the owner, ADDR[9:0], WE (forced to 0 for IF) and WDATA. Go to ISSUE.
- ISSUE
  - MEM_EN = 1, MEM_WE = registered WE, MEM_ADDR/MEM_DIN from the registers.
  - Write: go to RESP.
  - Read: load the wait counter with MEM_LAT-1 and go to WAIT.
- WAIT
  - MEM_EN = 0. Decrement the counter each cycle.
  - At count 0: capture MEM_DOUT into RDATA and go to RESP.
- RESP
  - Owner's ACK = 1 for exactly one cycle.
  - Update the last-grant register to the owner. Go to IDLE.
- Arbitration
  - Single REQ: that requester wins.
  - Both REQ: the requester not recorded in last-grant wins.
  - last-grant resets to DM, so IF wins the first tie.
- REQ is sampled only in IDLE. A REQ still high in the cycle after RESP is treated as a new request.
- Requesters may change ADDR/WE/WDATA after the IDLE sampling cycle; the block uses only registered copies.
- RDATA holds its value until the next read capture. Writes leave RDATA unchanged.
- MEM_EN, MEM_WE and the ACKs are decoded combinationally from the state and owner registers. They are glitch-free relative to CLK.
- Reset values: state IDLE; IF_ACK, DM_ACK, ERR, BUSY, MEM_EN and MEM_WE all 0; MEM_ADDR 10'h000; MEM_DIN 16'h0000; RDATA 16'h0000; counter 0.
- Reset mid-operation: the in-flight access is abandoned and no ACK is issued. MEM_WE drops asynchronously, so a write interrupted in ISSUE may or may not land in memory.

## Timing
- Count cycle n as the IDLE cycle in which REQ is sampled.
- Read: ISSUE in n+1, WAIT in n+2 .. n+1+MEM_LAT, RESP/ACK in n+2+MEM_LAT. Latency is MEM_LAT+2 cycles (3 at the default).
- Write: ISSUE in n+1 (MEM_WE=1), RESP/ACK in n+2.
- Back-to-back: the next IDLE sampling cycle falls right after RESP.
  - Minimum read period: MEM_LAT+3 cycles.
  - Minimum write period: 3 cycles.
- With both requesters continuously requesting, grants strictly alternate IF, DM, IF, …

## Configuration
- Macro: ADDR_RANGE_CHECK_EN.
- Defined:
  - In IDLE, a granted address with ADDR[15:10] != 0 is flagged as rejected.
  - ISSUE then keeps MEM_EN = 0 and MEM_WE = 0, WAIT is skipped, and the FSM goes to RESP.
  - In RESP the owner's ACK and ERR are 1 together, and RDATA is set to 16'h0000.
  - Rejected accesses still update last-grant.
- Undefined:
  - ADDR[15:10] is ignored and the address is silently truncated.
  - ERR is tied to 0. No range-check logic is synthesised.

## Test plan
- Reset, then IF_REQ with IF_ADDR=16'h0005 and memory[5]=16'hBEEF, MEM_LAT=1 → MEM_EN=1 with MEM_ADDR=10'h005 in n+1; IF_ACK=1 and RDATA=16'hBEEF in n+3.
- DM write: DM_ADDR=16'h03FF, DM_WDATA=16'h1234, DM_WE=1 → MEM_WE=1 and MEM_ADDR=10'h3FF in n+1; DM_ACK in n+2. A following DM read of 16'h03FF returns 16'h1234.
- IF_REQ and DM_REQ held high together for 4 grants → ACK order IF, DM, IF, DM; no cycle has both ACKs high.
- MEM_LAT=3 build, IF read → IF_ACK exactly 5 cycles after the sampling cycle; MEM_EN high for one cycle only.
- DM_ADDR=16'h0401:
  - With ADDR_RANGE_CHECK_EN: no MEM_EN; DM_ACK=1 and ERR=1 in n+2; RDATA=16'h0000.
  - Without it: MEM_ADDR=10'h001, normal access, ERR=0.
- RST_N asserted during WAIT → BUSY, MEM_EN and ACKs go to 0 immediately; after release, a held IF_REQ is re-served from IDLE and wins arbitration.
